wb_traffic_gen: RTL
===================

WB_TRAFFIC_GEN -- requirements
Module: wb_traffic_gen

Interface
REQ-001 SHALL have parameter dw, default 32, meaning Wishbone data width (multiple of 8).
REQ-002 SHALL have parameter APP_AW, default 26, meaning Wishbone byte-address width.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning maximum cycles to wait for wb_ack_i on one beat.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: wb_clk_i is the only clock, and wb_rst_i is the asynchronous active-high reset.
REQ-005 wb_clk_i  in  1  sole clock, all logic on rising edge.
REQ-006 wb_rst_i  in  1  asynchronous active-high reset.
REQ-007 start_i  in  1  single-cycle test launch request.
REQ-008 base_addr_i  in  APP_AW  first byte address, sampled on accepted start.
REQ-009 len_i  in  8  burst length in words, sampled on accepted start; 0 means 256.
REQ-010 seed_i  in  dw  data-pattern seed, sampled on accepted start.
REQ-011 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master cycle, strobe, and write enable.
REQ-012 wb_addr_o  out  APP_AW  byte address; wb_dat_o  out  dw  write data; wb_sel_o  out  dw/8  byte selects; wb_cti_o  out  3  cycle type.
REQ-013 wb_ack_i  in  1  slave acknowledge; wb_dat_i  in  dw  read data.
REQ-014 busy_o  out  1  test in progress.
REQ-015 done_o  out  1  one-cycle completion pulse.
REQ-016 pass_o  out  1  last test had no mismatches and no timeout.
REQ-017 err_cnt_o  out  9  mismatch count of last test.
REQ-018 timeout_o  out  1  last test aborted on ack timeout.

Function
REQ-019 SHALL implement states IDLE, WRITE, GAP, READ, DONE.
REQ-020 IDLE: start_i=1 SHALL sample inputs, clear err_cnt_o/timeout_o/pass_o, reset beat index and timeout counter, and go to WRITE next cycle; start_i SHALL be ignored in every other state.
REQ-021 WRITE/READ SHALL drive wb_cyc_o=wb_stb_o=1 continuously across all beats of the burst; wb_we_o=1 in WRITE, 0 in READ; wb_sel_o all ones.
REQ-022 Beat k (0..N-1) SHALL present wb_addr_o = base + 4*k, modulo 2^APP_AW (address wrap allowed), and write data = seed + k, modulo 2^dw.
REQ-023 wb_cti_o SHALL be 3'b010 on beats 0..N-2 and 3'b111 on beat N-1; for N=1, 3'b111 on the only beat.
REQ-024 A beat SHALL complete on the rising edge where wb_ack_i=1 with stb asserted; address/data/cti SHALL hold stable until then, and the next beat SHALL present on the following cycle.
REQ-025 wb_ack_i while wb_stb_o=0 SHALL be ignored.
REQ-026 In READ, on each ack, wb_dat_i SHALL be compared to seed + k; on mismatch, err_cnt_o SHALL increment, saturating at 511.
REQ-027 After ack of beat N-1 in WRITE, the block SHALL deassert cyc/stb the next cycle, spend exactly one cycle in GAP, then enter READ at beat 0.
REQ-028 After ack of beat N-1 in READ, the block SHALL deassert cyc/stb and go to DONE.
REQ-029 DONE SHALL last one cycle with done_o=1, pass_o=(err_cnt==0 && !timeout), then go to IDLE.
REQ-030 The timeout counter SHALL reset on every ack; if it reaches TIMEOUT without ack in WRITE/READ, the block SHALL set timeout_o, drop cyc/stb the next cycle, and go to DONE with pass_o=0.
REQ-031 busy_o SHALL be 1 in WRITE, GAP, READ, DONE and 0 in IDLE.
REQ-032 err_cnt_o, pass_o, and timeout_o SHALL hold their values until the next accepted start.

Reset
REQ-033 wb_rst_i=1 SHALL immediately force state IDLE and all outputs to 0 (cyc, stb, we, addr, dat, sel, cti, busy, done, pass, err_cnt, timeout), including mid-burst; no partial beat SHALL continue after release.
REQ-034 The first start SHALL be accepted on the first rising edge after wb_rst_i deasserts.

Verification
REQ-035 base=0x100, len=4, seed=0xA0, slave acks every cycle, echoes memory -> writes 0x100..0x10C data A0..A3, cti 010,010,010,111; one GAP; reads match; done_o pulse; pass_o=1, err_cnt_o=0.
REQ-036 Same with read beat 2 corrupted -> err_cnt_o=1, pass_o=0.
REQ-037 len=1 -> single write and single read, each with cti=111; len=0 -> 256 beats per phase.
REQ-038 base=0x3FFFFFC, len=2 -> addresses 0x3FFFFFC, then 0x0000000 (wrap).
REQ-039 Slave never acks, TIMEOUT=1024 -> stb drops after 1024 cycles, timeout_o=1, done_o pulse, pass_o=0; ack inserted with 3-cycle wait states -> no timeout, pass_o=1.
REQ-040 wb_rst_i pulsed during READ beat 1 -> all outputs 0 the same cycle; a subsequent start runs a full test from WRITE.

Source files
------------

// File: rtl/wb_traffic_gen.sv
// wb_traffic_gen: Wishbone burst write/read-back traffic generator.
// A test writes N incrementing words (seed + k) to base + 4*k as one
// incrementing burst, idles one cycle, reads the same burst back and counts
// data mismatches. A stalled beat aborts the test after TIMEOUT cycles.
//
// Ports:
//   wb_clk_i, wb_rst_i           clock, async active-high reset
//   start_i                      launch a test (accepted only when idle)
//   base_addr_i, len_i, seed_i   test setup, sampled on accepted start
//   wb_*_o / wb_ack_i, wb_dat_i  Wishbone master port
//   busy_o, done_o               test running, one-cycle completion pulse
//   pass_o, err_cnt_o, timeout_o result of the last test
module wb_traffic_gen #(
  parameter int dw      = 32,
  parameter int APP_AW  = 26,
  parameter int TIMEOUT = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [APP_AW-1:0] base_addr_i,
  input  logic [7:0]        len_i,
  input  logic [dw-1:0]     seed_i,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [dw/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [8:0]        err_cnt_o,
  output logic              timeout_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;

  typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DONE} state_t;

  state_t            state;
  logic [APP_AW-1:0] base_q;
  logic [dw-1:0]     seed_q;
  logic [7:0]        last_q;   // N-1; len 0 wraps to 255, i.e. 256 beats
  logic [7:0]        beat;
  logic [TW-1:0]     tcnt;

  logic tmo_hit, last_ack, mismatch;

  // wb_dat_o carries seed + k in both phases, so it doubles as the expected
  // read-back value.
  assign tmo_hit  = !wb_ack_i && (tcnt == TW'(TIMEOUT - 1));
  assign last_ack = wb_ack_i && (beat == last_q);
  assign mismatch = (state == READ) && (wb_dat_i != wb_dat_o);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      base_q    <= '0;
      seed_q    <= '0;
      last_q    <= '0;
      beat      <= '0;
      tcnt      <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      wb_cti_o  <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
      err_cnt_o <= '0;
      timeout_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          base_q    <= base_addr_i;
          seed_q    <= seed_i;
          last_q    <= len_i - 8'd1;
          beat      <= '0;
          tcnt      <= '0;
          err_cnt_o <= '0;
          timeout_o <= 1'b0;
          pass_o    <= 1'b0;
          busy_o    <= 1'b1;
          wb_cyc_o  <= 1'b1;
          wb_stb_o  <= 1'b1;
          wb_we_o   <= 1'b1;
          wb_sel_o  <= '1;
          wb_addr_o <= base_addr_i;
          wb_dat_o  <= seed_i;
          wb_cti_o  <= (len_i == 8'd1) ? CTI_END : CTI_INC;
          state     <= WRITE;
        end

        WRITE, READ: begin
          if (wb_ack_i) begin
            tcnt <= '0;
            if (mismatch && err_cnt_o != 9'h1FF) err_cnt_o <= err_cnt_o + 9'd1;
            if (beat != last_q) begin
              beat      <= beat + 8'd1;
              wb_addr_o <= wb_addr_o + APP_AW'(4);
              wb_dat_o  <= wb_dat_o + dw'(1);
              wb_cti_o  <= (beat + 8'd1 == last_q) ? CTI_END : CTI_INC;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
          if (last_ack || tmo_hit) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_cti_o  <= '0;
            wb_addr_o <= '0;
            wb_dat_o  <= '0;
            timeout_o <= tmo_hit;
            if (state == WRITE && !tmo_hit) begin
              state <= GAP;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
              // final beat's mismatch is not yet in err_cnt_o
              pass_o <= !tmo_hit && (err_cnt_o == 9'd0) && !mismatch;
            end
          end
        end

        GAP: begin
          beat      <= '0;
          tcnt      <= '0;
          wb_cyc_o  <= 1'b1;
          wb_stb_o  <= 1'b1;
          wb_we_o   <= 1'b0;
          wb_sel_o  <= '1;
          wb_addr_o <= base_q;
          wb_dat_o  <= seed_q;
          wb_cti_o  <= (last_q == 8'd0) ? CTI_END : CTI_INC;
          state     <= READ;
        end

        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
